// File: rtl/latch_event_capture.sv
// -----------------------------------------------------------------------------
// latch_event_capture
//
// Brings the asynchronous D-latch output into the clk domain, debounces it and
// produces single-cycle rise/fall pulses aligned with the debounced level.
// Qualified rising events are also tallied in a saturating counter, which the
// synchronous control logic reads and clears.
//
// Parameters
//   SYNC_STAGES  synchronizer depth (>= 2)
//   DEBOUNCE     consecutive synchronized cycles a new level must hold (>= 1)
//   CNT_W        width of rise_cnt
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   latch_q   asynchronous level from the D-latch q output
//   cnt_clr   synchronous clear of rise_cnt and sat
//   filt_q    synchronized, debounced level
//   rise      one-cycle pulse when filt_q goes 0->1
//   fall      one-cycle pulse when filt_q goes 1->0
//   rise_cnt  saturating count of rise pulses
//   sat       sticky flag: rise_cnt has reached all-ones
// -----------------------------------------------------------------------------
module latch_event_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             latch_q,
  input  logic             cnt_clr,
  output logic             filt_q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             sat
);

  localparam int DCNT_W = $clog2(DEBOUNCE) + 1;
  localparam logic [DCNT_W-1:0] DLAST   = DCNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOW,
    QUAL_HI,
    ST_HIGH,
    QUAL_LO
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: latch_q is only ever observed through the last stage.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], latch_q};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              filt_nxt;
  logic              rise_nxt;
  logic              fall_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_LOW;
      dcnt   <= '0;
      filt_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      state  <= state_nxt;
      dcnt   <= dcnt_nxt;
      filt_q <= filt_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    filt_nxt  = filt_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ST_LOW: begin
        if (s) begin
          // The first differing sample already counts toward qualification,
          // so a one-cycle debounce commits immediately.
          if (DEBOUNCE == 1) begin
            state_nxt = ST_HIGH;
            filt_nxt  = 1'b1;
            rise_nxt  = 1'b1;
            dcnt_nxt  = '0;
          end else begin
            state_nxt = QUAL_HI;
            dcnt_nxt  = DCNT_W'(1);
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_nxt = ST_LOW;
          dcnt_nxt  = '0;
        end else if (dcnt == DLAST) begin
          state_nxt = ST_HIGH;
          filt_nxt  = 1'b1;
          rise_nxt  = 1'b1;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt + DCNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (DEBOUNCE == 1) begin
            state_nxt = ST_LOW;
            filt_nxt  = 1'b0;
            fall_nxt  = 1'b1;
            dcnt_nxt  = '0;
          end else begin
            state_nxt = QUAL_LO;
            dcnt_nxt  = DCNT_W'(1);
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_nxt = ST_HIGH;
          dcnt_nxt  = '0;
        end else if (dcnt == DLAST) begin
          state_nxt = ST_LOW;
          filt_nxt  = 1'b0;
          fall_nxt  = 1'b1;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt + DCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_LOW;
        dcnt_nxt  = '0;
        filt_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating rise counter. It advances on the same edge that registers rise,
  // and a clear coinciding with a rise keeps that rise as the first count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_cnt <= '0;
      sat      <= 1'b0;
    end else if (cnt_clr) begin
      rise_cnt <= rise_nxt ? CNT_W'(1) : '0;
      sat      <= 1'b0;
    end else if (rise_nxt) begin
      if (rise_cnt != CNT_MAX) begin
        rise_cnt <= rise_cnt + CNT_W'(1);
      end
      if (rise_cnt >= CNT_MAX - CNT_W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule
